// File: rtl/ofifo_drain_ctrl.sv
// Drain sequencer: pops rows out of the MAC-array output FIFO and writes them
// to consecutive partial-sum SRAM addresses, then pulses done.
module ofifo_drain_ctrl #(
    parameter int addr_w = 11,
    parameter int cnt_w  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [cnt_w-1:0]  num_rows,
    input  logic              ofifo_valid,
    input  logic              mem_busy,
    output logic              ofifo_rd,
    output logic              psum_cen,
    output logic              psum_wen,
    output logic [addr_w-1:0] psum_addr,
    output logic              busy,
    output logic              done,
    output logic [cnt_w-1:0]  count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [cnt_w-1:0]  count_q, count_d;
    logic [cnt_w-1:0]  nrows_q, nrows_d;
    logic [addr_w-1:0] base_q, base_d;
    logic [addr_w-1:0] addr_q, addr_d;

    logic              pop_s;
    logic [cnt_w-1:0]  count_inc_s;
    logic [addr_w-1:0] cur_addr_s;

    // Address of the row being written this cycle; wraps modulo 2**addr_w.
    always_comb begin
        cur_addr_s  = base_q + count_q[addr_w-1:0];
        count_inc_s = count_q + {{(cnt_w-1){1'b0}}, 1'b1};
        pop_s       = (state_q == ST_DRAIN) && ofifo_valid && !mem_busy;
    end

    // State, job parameters, row count and held SRAM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= {cnt_w{1'b0}};
            nrows_q <= {cnt_w{1'b0}};
            base_q  <= {addr_w{1'b0}};
            addr_q  <= {addr_w{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            nrows_q <= nrows_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        nrows_d = nrows_q;
        base_d  = base_q;
        addr_d  = pop_s ? cur_addr_s : addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = {cnt_w{1'b0}};
                    if (num_rows != {cnt_w{1'b0}}) begin
                        nrows_d = num_rows;
                        base_d  = base_addr;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pop_s) begin
                    count_d = count_inc_s;
                    if (count_inc_s == nrows_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pop/write strobes are Mealy so FIFO data, address and enables line up
    // in the same cycle; the address is held at the last written row otherwise.
    always_comb begin
        ofifo_rd  = pop_s;
        psum_cen  = !pop_s;
        psum_wen  = !pop_s;
        psum_addr = (state_q == ST_DRAIN) ? cur_addr_s : addr_q;
        busy      = (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
        count     = count_q;
    end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Directed bench for ofifo_drain_ctrl: streaming, stalls, wrap, zero-length,
// ignored restarts and asynchronous reset during a job.
module tb_ofifo_drain_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] num_rows;
    logic        ofifo_valid;
    logic        mem_busy;
    logic        ofifo_rd;
    logic        psum_cen;
    logic        psum_wen;
    logic [10:0] psum_addr;
    logic        busy;
    logic        done;
    logic [11:0] count;

    int n_checks = 0;
    int n_errors = 0;

    int pops, done_n, done_cyc, last_pop, bad_rd, overlap, busy_n;
    logic [10:0] pa[$];

    ofifo_drain_ctrl #(.addr_w(11), .cnt_w(12)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .ofifo_valid(ofifo_valid), .mem_busy(mem_busy),
        .ofifo_rd(ofifo_rd), .psum_cen(psum_cen), .psum_wen(psum_wen),
        .psum_addr(psum_addr), .busy(busy), .done(done), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int k);
        if (ofifo_rd) begin
            pops++;
            pa.push_back(psum_addr);
            last_pop = k;
        end
        if (ofifo_rd && !(ofifo_valid && !mem_busy)) bad_rd++;
        if (ofifo_rd && (psum_cen || psum_wen)) bad_rd++;
        if (!ofifo_rd && (!psum_cen || !psum_wen)) bad_rd++;
        if (done) begin
            done_n++;
            done_cyc = k;
        end
        if (done && busy) overlap++;
        if (busy) busy_n++;
    endtask

    // mode 0: streaming, 1: valid 1010.. with busy every 3rd cycle,
    // 2: streaming with start re-pulsed at cycles 3 and 6
    task automatic run_job(input logic [10:0] b, input logic [11:0] n,
                           input int mode, input int ncyc);
        pa.delete();
        pops = 0; done_n = 0; done_cyc = -1; last_pop = -1;
        bad_rd = 0; overlap = 0; busy_n = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_rows = n;
        ofifo_valid = 1'b1; mem_busy = 1'b0;
        @(negedge clk);
        sample(0);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start = 1'b0; base_addr = 11'd777; num_rows = 12'd2;
            ofifo_valid = 1'b1; mem_busy = 1'b0;
            if (mode == 1) begin
                ofifo_valid = (k % 2 == 1);
                mem_busy    = (k % 3 == 0);
            end
            if (mode == 2 && (k == 3 || k == 6)) start = 1'b1;
            @(negedge clk);
            sample(k);
        end
        @(posedge clk); #1;
        start = 1'b0; ofifo_valid = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic check_outs_reset(input string tag);
        check_eq({tag, "_rd"}, {31'd0, ofifo_rd}, 32'd0);
        check_eq({tag, "_cen"}, {31'd0, psum_cen}, 32'd1);
        check_eq({tag, "_wen"}, {31'd0, psum_wen}, 32'd1);
        check_eq({tag, "_addr"}, {21'd0, psum_addr}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_count"}, {20'd0, count}, 32'd0);
    endtask

    initial begin
        logic [10:0] exp_wrap [4];
        int idle_pops;
        exp_wrap[0] = 11'd2046; exp_wrap[1] = 11'd2047;
        exp_wrap[2] = 11'd0;    exp_wrap[3] = 11'd1;

        reset = 1'b0; start = 1'b0; base_addr = 11'd0; num_rows = 12'd0;
        ofifo_valid = 1'b1; mem_busy = 1'b0;

        // Reset held 3 cycles, then idle with valid high.
        repeat (3) @(posedge clk);
        #1;
        check_outs_reset("reset");
        reset = 1'b1;
        idle_pops = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ofifo_rd || busy || done || !psum_cen) idle_pops++;
        end
        check_eq("idle_activity", idle_pops, 32'd0);
        check_outs_reset("idle");
        ofifo_valid = 1'b0;

        // Streaming 8 rows from base 100.
        run_job(11'd100, 12'd8, 0, 15);
        check_eq("stream_pops", pops, 32'd8);
        for (int i = 0; i < 8 && i < pa.size(); i++)
            check_eq($sformatf("stream_addr%0d", i), {21'd0, pa[i]}, 32'd100 + i);
        check_eq("stream_last_pop", last_pop, 32'd8);
        check_eq("stream_done_cyc", done_cyc, 32'd9);
        check_eq("stream_done_n", done_n, 32'd1);
        check_eq("stream_busy_n", busy_n, 32'd8);
        check_eq("stream_bad_rd", bad_rd, 32'd0);
        check_eq("stream_overlap", overlap, 32'd0);
        check_eq("stream_count", {20'd0, count}, 32'd8);
        check_eq("stream_addr_hold", {21'd0, psum_addr}, 32'd107);

        // Stalls: pops land on cycles 1,5,7,11.
        run_job(11'd0, 12'd4, 1, 16);
        check_eq("stall_pops", pops, 32'd4);
        for (int i = 0; i < 4 && i < pa.size(); i++)
            check_eq($sformatf("stall_addr%0d", i), {21'd0, pa[i]}, i);
        check_eq("stall_last_pop", last_pop, 32'd11);
        check_eq("stall_done_cyc", done_cyc, 32'd12);
        check_eq("stall_busy_n", busy_n, 32'd11);
        check_eq("stall_bad_rd", bad_rd, 32'd0);
        check_eq("stall_count", {20'd0, count}, 32'd4);

        // Address wrap.
        run_job(11'd2046, 12'd4, 0, 8);
        check_eq("wrap_pops", pops, 32'd4);
        for (int i = 0; i < 4 && i < pa.size(); i++)
            check_eq($sformatf("wrap_addr%0d", i), {21'd0, pa[i]}, {21'd0, exp_wrap[i]});
        check_eq("wrap_done_cyc", done_cyc, 32'd5);

        // Zero-length job.
        run_job(11'd300, 12'd0, 0, 5);
        check_eq("zero_pops", pops, 32'd0);
        check_eq("zero_done_cyc", done_cyc, 32'd1);
        check_eq("zero_done_n", done_n, 32'd1);
        check_eq("zero_busy_n", busy_n, 32'd0);
        check_eq("zero_count", {20'd0, count}, 32'd0);
        check_eq("zero_addr_hold", {21'd0, psum_addr}, 32'd1);

        // Restart pulses in DRAIN and DONE are ignored.
        run_job(11'd10, 12'd5, 2, 12);
        check_eq("restart_pops", pops, 32'd5);
        if (pa.size() == 5) check_eq("restart_last_addr", {21'd0, pa[4]}, 32'd14);
        check_eq("restart_done_cyc", done_cyc, 32'd6);
        check_eq("restart_done_n", done_n, 32'd1);
        check_eq("restart_count", {20'd0, count}, 32'd5);

        // Reset after 3 of 8 pops.
        pops = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'd0; num_rows = 12'd8;
        ofifo_valid = 1'b1; mem_busy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (ofifo_rd) pops++;
            @(posedge clk); #1;
        end
        check_eq("abort_pops_before", pops, 32'd3);
        check_eq("abort_count_before", {20'd0, count}, 32'd3);
        reset = 1'b0;
        #1;
        check_outs_reset("abort");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_pops = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ofifo_rd || busy || done) idle_pops++;
        end
        check_eq("abort_idle_activity", idle_pops, 32'd0);
        check_eq("abort_idle_count", {20'd0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ofifo_drain_ctrl.md
# ofifo_drain_ctrl

Sequencer that empties the output FIFO (ofifo) of the MAC array into the partial-sum SRAM. After a `start` pulse it pops one `col*bw`-wide row per cycle whenever the ofifo reports a valid row and the SRAM port is free. Each popped row is written to consecutive SRAM addresses from a programmed base. It stops after a programmed row count and pulses `done`. The row data path runs directly from ofifo `out` to the SRAM `D` pin; this block generates only control and address.

## Interface
Parameters:
- addr_w, 11, SRAM address width (2048-entry psum SRAM)
- cnt_w, 12, row-count width (must hold 2**addr_w)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; block is in reset while `reset`=0
- start  in  1  one-cycle pulse, begins a drain job (sampled only in IDLE)
- base_addr  in  addr_w  first SRAM address of the job, latched at start
- num_rows  in  cnt_w  rows to drain, latched at start
- ofifo_valid  in  1  ofifo `o_valid`: a full row is readable this cycle
- mem_busy  in  1  SRAM port owned by another requester this cycle
- ofifo_rd  out  1  pop ofifo this cycle
- psum_cen  out  1  SRAM chip enable, active-low
- psum_wen  out  1  SRAM write enable, active-low
- psum_addr  out  addr_w  SRAM address
- busy  out  1  job in progress (DRAIN state)
- done  out  1  one-cycle pulse at job completion
- count  out  cnt_w  rows written in current/last job

## Operation
States: IDLE, DRAIN, DONE.
- IDLE:
  - `start`=1 with `num_rows`≠0: latch `base_addr`/`num_rows`, clear count, go to DRAIN.
  - `start`=1 with `num_rows`=0: clear count, go to DONE, no pops.
  - `start`=0: stay in IDLE.
- DRAIN:
  - Pop condition: `fire` = `ofifo_valid` & !`mem_busy`.
  - When `fire`=1: `ofifo_rd`=1, `psum_cen`=0, `psum_wen`=0 in the same cycle (Mealy, combinational from state and inputs). Count increments at the edge.
  - When count+1 = latched `num_rows` on a firing cycle: go to DONE.
  - When `fire`=0: no pop, CEN/WEN high, stay in DRAIN (stall indefinitely).
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `psum_addr` = latched base + count, truncated to addr_w (wraps modulo 2**addr_w).
  - In IDLE/DONE it holds its last value.
  - After reset it is 0.
- `start` in DRAIN or DONE is ignored; no re-latch, no queueing.
- `count` holds its final value after DONE until the next start.
- `ofifo_rd` is never asserted outside DRAIN. At most `num_rows` pops per job, so the next tile's rows are never consumed.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE; count=0; latched base=0 and num_rows=0.
  - Outputs: `ofifo_rd`=0, `psum_cen`=1, `psum_wen`=1, `psum_addr`=0, `busy`=0, `done`=0.
  - Reset asserted mid-job aborts immediately; no further pops. Pops already taken are not undone.
- Cycle 0 `start` pulse → DRAIN at cycle 1. The first pop is possible at cycle 1.
- Throughput: 1 row/cycle with `ofifo_valid`=1 and `mem_busy`=0 continuously. An N-row job then has the last pop at cycle N and `done` at cycle N+1.
- The ofifo presents row data combinationally from its read pointer. Data, `psum_addr`, CEN and WEN are therefore coherent in the pop cycle, and the SRAM captures on the same edge that advances the ofifo pointer.
- Simultaneous `ofifo_valid`=1 and `mem_busy`=1: no pop. `mem_busy` always wins.
- `busy`=1 exactly while in DRAIN. `done` and `busy` are never high together.

## Test plan
- Reset then idle: hold `reset`=0 for 3 cycles, release. Expect all outputs at reset values and no `ofifo_rd` for 20 cycles, even with `ofifo_valid`=1.
- Streaming job: `base_addr`=100, `num_rows`=8, `ofifo_valid`=1, `mem_busy`=0. Expect 8 consecutive pops at addresses 100..107, `done` 1 cycle after the last pop, `count`=8, and no 9th pop.
- Stalls: `num_rows`=4 with `ofifo_valid` toggling 1010… and `mem_busy` high every 3rd cycle. Expect a pop only when valid & !busy, addresses 0..3 with no gaps or repeats, and the `done` pulse after the 4th pop.
- Wrap and zero-length: `base_addr`=2046, `num_rows`=4 → addresses 2046, 2047, 0, 1. Separately, `num_rows`=0 → `done` at cycle 1, no pops, `count`=0.
- Mid-job events: `start` re-pulsed during DRAIN → ignored, job length unchanged. `reset` pulled low after 3 of 8 pops → outputs go to reset values asynchronously, and after release the block stays in IDLE with no pops.
